// File: rtl/itof_pkg.sv
// Shared float constants and the converter state encoding, imported by itof and the
// neighbouring float blocks (fdiv and friends).
package itof_pkg;

   typedef enum logic [3:0] {
      st_get_a     = 4'd0,
      st_convert_0 = 4'd1,
      st_convert_1 = 4'd2,
      st_normalise = 4'd3,
      st_round     = 4'd4,
      st_pack      = 4'd5,
      st_put_z     = 4'd6
   } itof_state_e;

   localparam int unsigned MANT_W = 23;
   localparam int unsigned EXP_W  = 8;

   localparam logic [EXP_W-1:0] EXP_BIAS   = 8'd127;
   localparam logic [31:0]      FLOAT_ZERO = 32'h0000_0000;

endpackage : itof_pkg

// File: rtl/itof.sv
// Sequential int32 -> IEEE-754 single converter with stb/ack handshakes on both sides.
// ITOF_ROUND_EN selects round-to-nearest-even; without it the round step truncates.
//
// state        | meaning
// -------------+-----------------------------------------------
// st_get_a     | raise input_a_ack, wait for input_a_stb
// st_convert_0 | split sign, take magnitude
// st_convert_1 | zero shortcut or seed exponent at 31
// st_normalise | shift left one bit per clock until msb set
// st_round     | optional RNE increment with exponent carry
// st_pack      | assemble sign / biased exponent / mantissa
// st_put_z     | hold output_z_stb until output_z_ack
module itof
   import itof_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   itof_state_e state_q, state_d;
   logic        ack_q, ack_d;
   logic        stb_q, stb_d;

   logic [31:0]       a_q, a_d;
   logic [31:0]       value_q, value_d;
   logic [31:0]       z_q, z_d;
   logic [31:0]       out_q, out_d;
   logic              z_s_q, z_s_d;
   logic [EXP_W-1:0]  z_e_q, z_e_d;
   // Hidden bit is implicit (value[31] after normalise), so only the fraction is stored.
   logic [MANT_W-1:0] z_m_q, z_m_d;

`ifdef ITOF_ROUND_EN
   logic            guard_q, guard_d;
   logic            round_bit_q, round_bit_d;
   logic            sticky_q, sticky_d;
   logic [MANT_W:0] m_inc;

   // Carry out of the fraction means 1.111..1 rounded up to 10.000..0.
   assign m_inc = {1'b0, z_m_q} + {{MANT_W{1'b0}}, 1'b1};
`endif

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      stb_d   = stb_q;
      a_d     = a_q;
      value_d = value_q;
      z_d     = z_q;
      out_d   = out_q;
      z_s_d   = z_s_q;
      z_e_d   = z_e_q;
      z_m_d   = z_m_q;
`ifdef ITOF_ROUND_EN
      guard_d     = guard_q;
      round_bit_d = round_bit_q;
      sticky_d    = sticky_q;
`endif
      case (state_q)
         st_get_a: begin
            ack_d = 1'b1;
            if (ack_q && input_a_stb) begin
               a_d     = input_a;
               ack_d   = 1'b0;
               state_d = st_convert_0;
            end
         end
         st_convert_0: begin
            z_s_d   = a_q[31];
            value_d = a_q[31] ? (~a_q + 32'd1) : a_q;
            state_d = st_convert_1;
         end
         st_convert_1: begin
            if (value_q == 32'd0) begin
               z_d     = FLOAT_ZERO;
               state_d = st_put_z;
            end else begin
               z_e_d   = 8'd31;
               state_d = st_normalise;
            end
         end
         st_normalise: begin
            if (!value_q[31]) begin
               value_d = {value_q[30:0], 1'b0};
               z_e_d   = z_e_q - 8'd1;
            end else begin
               z_m_d   = value_q[30:8];
`ifdef ITOF_ROUND_EN
               guard_d     = value_q[7];
               round_bit_d = value_q[6];
               sticky_d    = |value_q[5:0];
`endif
               state_d = st_round;
            end
         end
         st_round: begin
`ifdef ITOF_ROUND_EN
            if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
               z_m_d = m_inc[MANT_W-1:0];
               if (m_inc[MANT_W]) begin
                  z_e_d = z_e_q + 8'd1;
               end
            end
`endif
            state_d = st_pack;
         end
         st_pack: begin
            z_d     = {z_s_q, z_e_q + EXP_BIAS, z_m_q};
            state_d = st_put_z;
         end
         st_put_z: begin
            stb_d = 1'b1;
            out_d = z_q;
            if (stb_q && output_z_ack) begin
               stb_d   = 1'b0;
               state_d = st_get_a;
            end
         end
         default: begin
            state_d = st_get_a;
            ack_d   = 1'b0;
            stb_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= st_get_a;
         ack_q   <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         stb_q   <= stb_d;
      end
   end

   // Datapath carries no reset; every field is written before it is consumed.
   always_ff @(posedge clk) begin
      a_q     <= a_d;
      value_q <= value_d;
      z_q     <= z_d;
      out_q   <= out_d;
      z_s_q   <= z_s_d;
      z_e_q   <= z_e_d;
      z_m_q   <= z_m_d;
`ifdef ITOF_ROUND_EN
      guard_q     <= guard_d;
      round_bit_q <= round_bit_d;
      sticky_q    <= sticky_d;
`endif
   end

   assign input_a_ack  = ack_q;
   assign output_z_stb = stb_q;
   assign output_z     = out_q;

endmodule : itof

// File: tb/tb_itof.sv
// Self-checking bench for itof: directed corner values, randomized operands with random
// backpressure, a long output hold and a reset pulse in the middle of a conversion.
module tb_itof;

   logic        clk;
   logic        rst;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   int n_checks = 0;
   int n_fail   = 0;

   itof dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
      end
   endtask

   // Index of the highest set bit of a nonzero magnitude.
   function automatic int msb_pos(input longint mag);
      int p = 0;
      for (int i = 0; i < 33; i++) if ((mag >> i) != 0) p = i;
      return p;
   endfunction

   function automatic longint magnitude(input logic [31:0] a);
      longint v = longint'(a);
      return a[31] ? (64'sh1_0000_0000 - v) : v;
   endfunction

   // Reference conversion from plain arithmetic on the integer magnitude.
   function automatic logic [31:0] ref_itof(input logic [31:0] a);
      longint mag, mant, rem, half;
      int     p, sh;
      logic   s;
      logic [31:0] m32;
      s   = a[31];
      mag = magnitude(a);
      if (mag == 0) return 32'h0;
      p = msb_pos(mag);
      if (p <= 23) begin
         mant = mag << (23 - p);
      end else begin
         sh   = p - 23;
         mant = mag >> sh;
         rem  = mag - (mant << sh);
         half = longint'(1) << (sh - 1);
`ifdef ITOF_ROUND_EN
         if (rem > half || (rem == half && mant[0])) mant = mant + 1;
         if (mant == (longint'(1) << 24)) begin
            mant = mant >> 1;
            p    = p + 1;
         end
`else
         if (rem > half) mant = mant;
`endif
      end
      m32 = 32'(mant);
      return {s, 8'(p + 127), m32[22:0]};
   endfunction

   function automatic int ref_lat(input logic [31:0] a);
      longint mag = magnitude(a);
      if (mag == 0) return 3;
      return 6 + (31 - msb_pos(mag));
   endfunction

   // One full transaction: offer operand, time the result, hold for 'hold' cycles, accept.
   task automatic run_one(input logic [31:0] a, input logic [31:0] want, input int hold);
      int          cnt;
      logic [31:0] held;
      @(negedge clk);
      input_a     = a;
      input_a_stb = 1'b1;
      cnt = 0;
      while (!input_a_ack && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (!input_a_ack) begin
         chk("accept_timeout", 32'd0, 32'd1);
         input_a_stb = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      input_a_stb = 1'b0;
      input_a     = $urandom;
      chk("ack_drop", {31'd0, input_a_ack}, 32'd0);
      cnt = 0;
      while (!output_z_stb && cnt < 60) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      chk("latency", 32'(cnt), 32'(ref_lat(a)));
      chk("result", output_z, want);
      chk("ack_in_put_z", {31'd0, input_a_ack}, 32'd0);
      held = output_z;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_z", output_z, held);
         chk("hold_stb", {31'd0, output_z_stb}, 32'd1);
         chk("hold_ack", {31'd0, input_a_ack}, 32'd0);
      end
      output_z_ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      output_z_ack = 1'b0;
      chk("stb_drop", {31'd0, output_z_stb}, 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      int          cnt;
      rst          = 1'b0;
      input_a      = 32'd0;
      input_a_stb  = 1'b0;
      output_z_ack = 1'b0;
      #1;
      chk("reset_ack", {31'd0, input_a_ack}, 32'd0);
      chk("reset_stb", {31'd0, output_z_stb}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      run_one(32'd1,        32'h3F80_0000, 0);
      run_one(32'd0,        32'h0000_0000, 0);
      run_one(32'hFFFF_FFFF, 32'hBF80_0000, 1);
      run_one(32'h8000_0000, 32'hCF00_0000, 0);
`ifdef ITOF_ROUND_EN
      run_one(32'h7FFF_FFFF, 32'h4F00_0000, 0);
      run_one(32'd16777219,  32'h4B80_0002, 0);
`else
      run_one(32'h7FFF_FFFF, 32'h4EFF_FFFF, 0);
      run_one(32'd16777219,  32'h4B80_0001, 0);
`endif
      run_one(32'd16777217, 32'h4B80_0000, 0);
      run_one(32'd12345,    ref_itof(32'd12345), 10);

      // Reset pulse while the converter is shifting.
      @(negedge clk);
      input_a     = 32'd1;
      input_a_stb = 1'b1;
      cnt = 0;
      while (!input_a_ack && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      @(posedge clk);
      @(negedge clk);
      input_a_stb = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midreset_ack", {31'd0, input_a_ack}, 32'd0);
      chk("midreset_stb", {31'd0, output_z_stb}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      run_one(32'hFFFF_FF80, ref_itof(32'hFFFF_FF80), 0);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0: r = $urandom;
            1: r = $urandom_range(0, 300);
            2: r = -$urandom_range(0, 300);
            default: r = $urandom >> $urandom_range(0, 31);
         endcase
         run_one(r, ref_itof(r), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_itof
